// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store data-memory controller.
//   lsu_funct3_e : access-width encodings carried on the request funct3 field
//   lsu_state_e  : controller FSM states
//   lsu_size     : access size in bytes for a funct3 code
//   lsu_f3_ok    : funct3 code is a legal access width
//   lsu_extract  : pick the addressed bytes out of a two-word window and extend
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'd0,
        LSU_H  = 3'd1,
        LSU_W  = 3'd2,
        LSU_BU = 3'd4,
        LSU_HU = 3'd5
    } lsu_funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SECOND = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    // Illegal codes report size 1 so the crossing logic stays well defined;
    // they are rejected separately.
    function automatic logic [2:0] lsu_size(input logic [2:0] f3);
        case (f3)
            LSU_H, LSU_HU: return 3'd2;
            LSU_W:         return 3'd4;
            default:       return 3'd1;
        endcase
    endfunction

    function automatic logic lsu_f3_ok(input logic [2:0] f3);
        case (f3)
            LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // Byte k of the access lives at window position off+k; positions 4..7
    // come from the upper word.
    function automatic logic [31:0] lsu_extract(input logic [31:0] lower,
                                                input logic [31:0] upper,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [3:0][7:0] b;
        logic [2:0]      pos;
        b = '0;
        for (int k = 0; k < 4; k++) begin
            pos  = {1'b0, off} + 3'(k);
            b[k] = pos[2] ? upper[{pos[1:0], 3'b000} +: 8]
                          : lower[{pos[1:0], 3'b000} +: 8];
        end
        case (f3)
            LSU_B:   return {{24{b[0][7]}}, b[0]};
            LSU_BU:  return {24'd0, b[0]};
            LSU_H:   return {{16{b[1][7]}}, b[1], b[0]};
            LSU_HU:  return {16'd0, b[1], b[0]};
            LSU_W:   return b;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_bank.sv
// lsu_byte_bank: one 8-bit lane of the data memory.
//   i_clk : clock (synchronous write)
//   we    : write enable
//   addr  : word index
//   wdata : byte to write
//   rdata : byte at addr (combinational read)
// Contents are deliberately not reset.
module lsu_byte_bank #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: byte-addressed load/store controller over four byte lanes.
//   i_clk, i_rst                 : clock, async active-high reset
//   i_req_valid / o_req_ready    : request handshake
//   i_req_addr, i_req_write,
//   i_req_funct3, i_req_wdata    : request payload (byte address, store flag,
//                                  width code, LSB-aligned store data)
//   o_rsp_valid / i_rsp_ready    : response handshake
//   o_rsp_rdata, o_rsp_err       : extended load data, rejection flag
// Accesses that straddle a word boundary take an extra SECOND cycle for the
// upper word when SPLIT_EN=1, and are rejected otherwise.
module lsu_dmem_ctrl
    import lsu_pkg::*;
#(
    parameter int DMEM_ADDR = 13,
    parameter bit SPLIT_EN  = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [DMEM_ADDR-1:0] i_req_addr,
    input  logic                 i_req_write,
    input  logic [2:0]           i_req_funct3,
    input  logic [31:0]          i_req_wdata,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [31:0]          o_rsp_rdata,
    output logic                 o_rsp_err
);

    localparam int WORD_W = DMEM_ADDR - 2;
    localparam int DEPTH  = 2 ** WORD_W;

    lsu_state_e        state;
    logic              accept;
    logic [WORD_W-1:0] req_word;
    logic [1:0]        req_off;
    logic [2:0]        req_size;
    logic              req_cross;
    logic              req_err;

    logic [WORD_W-1:0] sv_word;
    logic [1:0]        sv_off;
    logic [2:0]        sv_funct3;
    logic              sv_write;
    logic [31:0]       sv_wdata;
    logic [31:0]       sv_lower;

    logic [WORD_W-1:0] lane_addr;
    logic [3:0]        lane_we;
    logic [31:0]       lane_wdata;
    logic [31:0]       rd_word;

    assign o_req_ready = (state == ST_IDLE) || ((state == ST_RESP) && i_rsp_ready);
    assign accept      = i_req_valid && o_req_ready;

    assign req_word  = i_req_addr[DMEM_ADDR-1:2];
    assign req_off   = i_req_addr[1:0];
    assign req_size  = lsu_size(i_req_funct3);
    assign req_cross = ({2'b00, req_off} + {1'b0, req_size}) > 4'd4;

    // A crossing access at the last word would need word 0 as its upper half;
    // that wrap is refused.
    assign req_err = !lsu_f3_ok(i_req_funct3)
                   || (i_req_write && ((i_req_funct3 == LSU_BU) || (i_req_funct3 == LSU_HU)))
                   || (req_cross && (!SPLIT_EN || (&req_word)));

    // Lane k-index is (lane - offset) mod 4. Lanes at or above the offset
    // belong to the lower word, lanes below it to the upper word.
    always_comb begin
        logic [1:0] k;
        k          = '0;
        lane_we    = '0;
        lane_wdata = '0;
        lane_addr  = req_word;
        if (state == ST_SECOND) begin
            lane_addr = sv_word + 1'b1;
            for (int l = 0; l < 4; l++) begin
                k                   = 2'(l) - sv_off;
                lane_wdata[8*l +: 8] = sv_wdata[{k, 3'b000} +: 8];
                lane_we[l]          = sv_write && (2'(l) < sv_off)
                                      && ({1'b0, k} < lsu_size(sv_funct3));
            end
        end else begin
            for (int l = 0; l < 4; l++) begin
                k                   = 2'(l) - req_off;
                lane_wdata[8*l +: 8] = i_req_wdata[{k, 3'b000} +: 8];
                lane_we[l]          = accept && i_req_write && !req_err
                                      && (2'(l) >= req_off) && ({1'b0, k} < req_size);
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        lsu_byte_bank #(
            .DEPTH (DEPTH),
            .AW    (WORD_W)
        ) u_bank (
            .i_clk (i_clk),
            .we    (lane_we[g]),
            .addr  (lane_addr),
            .wdata (lane_wdata[8*g +: 8]),
            .rdata (rd_word[8*g +: 8])
        );
    end

    // In SECOND the read port shows the upper word while sv_lower holds the
    // lower word captured at acceptance.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            sv_word     <= '0;
            sv_off      <= '0;
            sv_funct3   <= '0;
            sv_write    <= 1'b0;
            sv_wdata    <= '0;
            sv_lower    <= '0;
        end else begin
            case (state)
                ST_SECOND: begin
                    state       <= ST_RESP;
                    o_rsp_valid <= 1'b1;
                    o_rsp_err   <= 1'b0;
                    o_rsp_rdata <= sv_write ? 32'd0
                                            : lsu_extract(sv_lower, rd_word, sv_off, sv_funct3);
                end
                default: begin
                    if (o_req_ready) begin
                        state       <= ST_IDLE;
                        o_rsp_valid <= 1'b0;
                        if (accept) begin
                            sv_word   <= req_word;
                            sv_off    <= req_off;
                            sv_funct3 <= i_req_funct3;
                            sv_write  <= i_req_write;
                            sv_wdata  <= i_req_wdata;
                            sv_lower  <= rd_word;
                            if (req_err) begin
                                state       <= ST_RESP;
                                o_rsp_valid <= 1'b1;
                                o_rsp_err   <= 1'b1;
                                o_rsp_rdata <= '0;
                            end else if (req_cross) begin
                                state <= ST_SECOND;
                            end else begin
                                state       <= ST_RESP;
                                o_rsp_valid <= 1'b1;
                                o_rsp_err   <= 1'b0;
                                o_rsp_rdata <= i_req_write ? 32'd0
                                                           : lsu_extract(rd_word, rd_word, req_off, i_req_funct3);
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// tb_lsu_dmem_ctrl: self-checking bench for lsu_dmem_ctrl with a byte-array
// reference memory, directed scenarios and randomized load/store traffic.
module tb_lsu_dmem_ctrl;

    localparam int DA        = 13;
    localparam int MEM_BYTES = 2 ** DA;
    localparam int NWORDS    = MEM_BYTES / 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic [DA-1:0] i_req_addr = '0;
    logic          i_req_write = 1'b0;
    logic [2:0]    i_req_funct3 = 3'd0;
    logic [31:0]   i_req_wdata = '0;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b1;
    logic [31:0]   o_rsp_rdata;
    logic          o_rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  model_mem [MEM_BYTES];
    logic [31:0] last_rd;
    logic        last_err;
    int          last_lat;

    always #5 i_clk = ~i_clk;

    lsu_dmem_ctrl #(
        .DMEM_ADDR (DA),
        .SPLIT_EN  (1'b1)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_addr   (i_req_addr),
        .i_req_write  (i_req_write),
        .i_req_funct3 (i_req_funct3),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err)
    );

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int model_size(input int f3);
        case (f3)
            0, 4:    return 1;
            1, 5:    return 2;
            2:       return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input int a, input int f3);
        logic [31:0] v;
        v = 0;
        for (int k = 0; k < model_size(f3); k++) v = v | (32'(model_mem[a + k]) << (8 * k));
        if (f3 == 0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic bit model_err(input int a, input bit wr, input int f3);
        int sz;
        sz = model_size(f3);
        if (sz == 0) return 1'b1;
        if (wr && f3 >= 4) return 1'b1;
        if ((a % 4) + sz > 4 && a + sz > MEM_BYTES) return 1'b1;
        return 1'b0;
    endfunction

    // Issues one request, waits for acceptance and for its response; latency
    // counts clock edges from acceptance to the first cycle o_rsp_valid is seen.
    task automatic apply_stimulus(input logic [DA-1:0] addr, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] wd, output logic [31:0] rd,
                                  output logic err, output int lat);
        int guard;
        i_req_valid  = 1'b1;
        i_req_addr   = addr;
        i_req_write  = wr;
        i_req_funct3 = f3;
        i_req_wdata  = wd;
        guard = 0;
        while (!o_req_ready && guard < 8) begin
            @(posedge i_clk); #1;
            guard++;
        end
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        lat = 1;
        while (!o_rsp_valid && lat < 8) begin
            @(posedge i_clk); #1;
            lat++;
        end
        if (!o_rsp_valid) lat = 99;
        rd  = o_rsp_rdata;
        err = o_rsp_err;
    endtask

    task automatic run_op(input int a, input bit wr, input int f3, input logic [31:0] wd, input string tag);
        bit          e;
        int          sz;
        int          exp_lat;
        logic [31:0] exp_rd;
        sz      = model_size(f3);
        e       = model_err(a, wr, f3);
        exp_rd  = (e || wr) ? 32'd0 : model_load(a, f3);
        exp_lat = (!e && ((a % 4) + sz > 4)) ? 2 : 1;
        apply_stimulus(DA'(a), wr, 3'(f3), wd, last_rd, last_err, last_lat);
        check_output({tag, "_rdata"}, last_rd, exp_rd);
        check_output({tag, "_err"}, 32'(last_err), 32'(e));
        check_output({tag, "_lat"}, 32'(last_lat), 32'(exp_lat));
        if (!e && wr) begin
            for (int k = 0; k < sz; k++) model_mem[a + k] = wd[8*k +: 8];
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int          a;
        logic [31:0] hold_exp;

        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check_output("rst_valid", 32'(o_rsp_valid), 32'd0);
        check_output("rst_rdata", o_rsp_rdata, 32'd0);
        check_output("rst_err", 32'(o_rsp_err), 32'd0);
        check_output("rst_ready", 32'(o_req_ready), 32'd1);

        // Give the exercised regions known contents.
        for (int w = 0; w < 64; w++) run_op(w * 4, 1'b1, 2, $urandom, "init");
        for (int w = NWORDS - 4; w < NWORDS; w++) run_op(w * 4, 1'b1, 2, $urandom, "init");

        run_op('h10, 1'b1, 2, 32'h1122_3344, "sw10");
        run_op('h10, 1'b0, 2, 32'h0, "lw10");
        check_output("lw10_const", last_rd, 32'h1122_3344);

        run_op('h21, 1'b1, 0, 32'h0000_0080, "sb21");
        run_op('h21, 1'b0, 0, 32'h0, "lb21");
        check_output("lb21_const", last_rd, 32'hFFFF_FF80);
        run_op('h21, 1'b0, 4, 32'h0, "lbu21");
        check_output("lbu21_const", last_rd, 32'h0000_0080);

        run_op('h0E, 1'b1, 2, 32'hAABB_CCDD, "sw0e");
        run_op('h0E, 1'b0, 2, 32'h0, "lw0e");
        check_output("lw0e_const", last_rd, 32'hAABB_CCDD);
        run_op('h0F, 1'b0, 1, 32'h0, "lh0f");
        check_output("lh0f_const", last_rd, 32'hFFFF_BBCC);
        run_op('h0C, 1'b0, 2, 32'h0, "lw0c");
        run_op('h10, 1'b0, 2, 32'h0, "lw10b");

        run_op(MEM_BYTES - 3, 1'b1, 2, 32'hDEAD_BEEF, "sw_top_cross");
        check_output("sw_top_cross_errc", 32'(last_err), 32'd1);
        run_op('h40, 1'b1, 5, 32'h0000_5A5A, "sh_f5");
        check_output("sh_f5_errc", 32'(last_err), 32'd1);
        run_op('h40, 1'b0, 3, 32'h0, "f3_3");
        check_output("f3_3_errc", 32'(last_err), 32'd1);
        run_op(MEM_BYTES - 4, 1'b0, 2, 32'h0, "lw_top");
        run_op('h40, 1'b0, 2, 32'h0, "lw40");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) a = $urandom_range(0, 251);
            else                           a = $urandom_range(MEM_BYTES - 16, MEM_BYTES - 1);
            run_op(a, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom, "rnd");
        end

        for (int i = 0; i < 10; i++) begin
            i_req_valid  = 1'b1;
            i_req_addr   = DA'('h80 + 4 * i);
            i_req_write  = 1'b0;
            i_req_funct3 = 3'd2;
            @(posedge i_clk); #1;
            check_output("b2b_valid", 32'(o_rsp_valid), 32'd1);
            check_output("b2b_rdata", o_rsp_rdata, model_load('h80 + 4 * i, 2));
        end
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b0;
        hold_exp    = model_load('h80 + 36, 2);
        for (int j = 0; j < 3; j++) begin
            @(posedge i_clk); #1;
            check_output("hold_valid", 32'(o_rsp_valid), 32'd1);
            check_output("hold_rdata", o_rsp_rdata, hold_exp);
            check_output("hold_err", 32'(o_rsp_err), 32'd0);
            check_output("hold_ready", 32'(o_req_ready), 32'd0);
        end
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        check_output("drain_valid", 32'(o_rsp_valid), 32'd0);

        i_req_valid  = 1'b1;
        i_req_addr   = DA'('h1E);
        i_req_write  = 1'b1;
        i_req_funct3 = 3'd2;
        i_req_wdata  = 32'hCAFE_F00D;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        check_output("second_valid", 32'(o_rsp_valid), 32'd0);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        check_output("rst2_valid", 32'(o_rsp_valid), 32'd0);
        i_rst = 1'b0;
        model_mem['h1E] = 8'h0D;
        model_mem['h1F] = 8'hF0;
        @(posedge i_clk); #1;
        check_output("rst2_ready", 32'(o_req_ready), 32'd1);
        check_output("rst2_valid2", 32'(o_rsp_valid), 32'd0);
        run_op('h1C, 1'b0, 2, 32'h0, "rst2_lower");
        run_op('h20, 1'b0, 2, 32'h0, "rst2_upper");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_ctrl.md
LSU_DMEM_CTRL -- requirements
Module: lsu_dmem_ctrl

Interface
REQ-001 SHALL have parameter DMEM_ADDR, default 13, byte-address width; memory depth is 2**(DMEM_ADDR-2) 32-bit words.
REQ-002 SHALL have parameter SPLIT_EN, default 1; 1 = word-crossing accesses are split into two cycles, 0 = such accesses return an error.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  asynchronous, active-high reset.
REQ-005 i_req_valid  input  1  request present.
REQ-006 o_req_ready  output  1  request accepted when i_req_valid && o_req_ready.
REQ-007 i_req_addr  input  DMEM_ADDR  byte address.
REQ-008 i_req_write  input  1  1 = store, 0 = load.
REQ-009 i_req_funct3  input  3  0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-010 i_req_wdata  input  32  store data, LSB-aligned.
REQ-011 o_rsp_valid  output  1  response present.
REQ-012 i_rsp_ready  input  1  response consumed when o_rsp_valid && i_rsp_ready.
REQ-013 o_rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 o_rsp_err  output  1  request rejected; no memory write took place.

Function
REQ-015 Memory SHALL be four 8-bit byte lanes indexed by word = addr[DMEM_ADDR-1:2]; byte k of an access maps to lane (addr[1:0]+k) mod 4, word +1 on carry.
REQ-016 Size SHALL be 1/2/4 bytes for funct3 B,BU / H,HU / W; crossing = addr[1:0]+size > 4.
REQ-017 Error SHALL be raised for funct3 3, 6, 7; store with funct3 4 or 5; crossing with SPLIT_EN=0; crossing at the last word (no wrap to word 0).
REQ-018 The error check SHALL complete at acceptance; an errored request writes nothing and responds after 1 cycle.
REQ-019 FSM states SHALL be IDLE, SECOND, RESP.
REQ-020 IDLE: a non-crossing or errored request goes to RESP; a valid crossing request goes to SECOND.
REQ-021 SECOND: SHALL perform the upper-word part unconditionally, then go to RESP.
REQ-022 RESP: if i_rsp_ready, go to IDLE, or accept a new request in the same cycle (back-to-back).
REQ-023 o_req_ready SHALL be 1 only in IDLE, or in RESP with i_rsp_ready=1.
REQ-024 Latency SHALL be: non-crossing = o_rsp_valid in the cycle after acceptance; crossing = two cycles after acceptance.
REQ-025 With i_rsp_ready held at 1, aligned accesses SHALL sustain 1 request per cycle.
REQ-026 Stores SHALL write only the addressed lanes: the lower word at acceptance, the upper word in SECOND.
REQ-027 Crossing loads SHALL capture lower-word bytes at acceptance, assemble them in SECOND, then extend.
REQ-028 Loads SHALL sign-extend for B/H and zero-extend for BU/HU.
REQ-029 o_rsp_rdata and o_rsp_err SHALL be registered and held stable while o_rsp_valid && !i_rsp_ready.
REQ-030 A load to a byte stored by the immediately preceding accepted store SHALL return the new data.

Reset
REQ-031 Reset SHALL set state IDLE, o_rsp_valid 0, o_rsp_rdata 0, o_rsp_err 0; o_req_ready is 1 after release.
REQ-032 Memory contents SHALL NOT be reset.
REQ-033 Reset during SECOND SHALL abandon the upper half; the lower-half write is retained and no response is issued.

Structure
REQ-034 Package lsu_pkg SHALL hold the funct3 enum (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU) and the FSM state typedef.
REQ-035 One sub-module lsu_byte_bank (8-bit lane, DEPTH param, write enable, address, combinational read) SHALL be instantiated four times.

Verification
REQ-036 SW 0x11223344 @0x10, then LW @0x10 -> rdata 0x11223344, err 0, response 1 cycle after each accept.
REQ-037 SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080.
REQ-038 SW 0xAABBCCDD @0x0E (crossing) -> lane writes at words 3 and 4, response 2 cycles after accept; LW @0x0E -> 0xAABBCCDD; LH @0x0F -> 0xFFFFBBCC.
REQ-039 SW @top word +1 (crossing past end), SH funct3=5, and funct3=3 -> err 1, rdata 0, memory unchanged.
REQ-040 Ten back-to-back LW with i_rsp_ready=1 -> ten responses on consecutive cycles; then i_rsp_ready=0 for 3 cycles -> rdata and err held, o_req_ready 0.
REQ-041 Assert i_rst in SECOND of a crossing SW -> o_rsp_valid 0 next cycle; lower bytes written; upper bytes unchanged.
